// File: rtl/alu_cmd_seq.sv
// rtl/alu_cmd_seq.sv - command-driven accumulator sequencer in front of a 4-bit combinational ALU
// MUL is done as repeated ALU ADDs of the accumulator into a running product.
module alu_cmd_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [1:0]       alu_func,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_c,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  localparam logic [2:0] OP_LOAD = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_READ = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;
  localparam logic [1:0] FN_ADD  = 2'b11;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_RESP} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_prod;
  logic [WIDTH-1:0] r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_data;
  logic             w_accept;

  assign w_accept  = cmd_valid && (r_state == S_IDLE);
  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_data  = r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    alu_func = 2'b00;
    alu_a    = '0;
    alu_b    = '0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_next = (cmd_op == OP_MUL) ? S_MUL : S_EXEC;
        end
      end
      S_EXEC: begin
        // Only the logic/arithmetic opcodes (op[2]==0) go through the ALU.
        if (!r_op[2]) begin
          alu_func = r_op[1:0];
          alu_a    = r_acc;
          alu_b    = r_data;
        end
        w_next = S_RESP;
      end
      S_MUL: begin
        if (r_cnt != '0) begin
          alu_func = FN_ADD;
          alu_a    = r_prod;
          alu_b    = r_acc;
        end else begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_prod <= '0;
      r_cnt  <= '0;
      r_op   <= '0;
      r_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op   <= cmd_op;
            r_data <= cmd_data;
            if (cmd_op == OP_MUL) begin
              r_prod <= '0;
              r_cnt  <= cmd_data;
            end
          end
        end
        S_EXEC: begin
          case (r_op)
            OP_LOAD: r_acc <= r_data;
            OP_READ: r_acc <= r_acc;
            OP_CLR:  r_acc <= '0;
            default: r_acc <= alu_c;
          endcase
        end
        S_MUL: begin
          if (r_cnt != '0) begin
            r_prod <= alu_c;
            r_cnt  <= r_cnt - ONE;
          end else begin
            r_acc <= r_prod;
          end
        end
        default: r_acc <= r_acc;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_seq.sv
// tb/tb_alu_cmd_seq.sv - directed bench for alu_cmd_seq with a cycle-level reference model
module tb_alu_cmd_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'b000;
  logic [3:0] cmd_data = 4'h0;
  logic [1:0] alu_func;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_c;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [3:0] rsp_data;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  alu_cmd_seq #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .alu_func(alu_func), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    case (alu_func)
      2'b00:   alu_c = alu_a & alu_b;
      2'b01:   alu_c = alu_a | alu_b;
      2'b10:   alu_c = alu_a - alu_b;
      default: alu_c = alu_a + alu_b;
    endcase
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_op(input int acc, input int op, input int d);
    case (op)
      0: return acc & d;
      1: return acc | d;
      2: return (acc - d) & 15;
      3: return (acc + d) & 15;
      4: return d;
      5: return (acc * d) & 15;
      6: return acc;
      default: return 0;
    endcase
  endfunction

  // Reference model: one outstanding command, response due at accept+2 (+data for MUL).
  initial begin
    bit pending = 0;
    int m_acc = 0, m_old = 0, m_op = 0, m_data = 0, acc_cyc = 0, rsp_cyc = 0;
    int ef, ea, eb, rel;
    bit ev;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_alu_func", alu_func, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        pending = 0;
        m_acc = 0;
      end else begin
        rel = cyc - acc_cyc;
        ev = pending && (cyc >= rsp_cyc);
        ef = 0; ea = 0; eb = 0;
        if (pending && !ev) begin
          if (m_op < 4) begin
            ef = m_op; ea = m_old; eb = m_data;
          end else if (m_op == 5 && rel <= m_data) begin
            ef = 3; ea = (m_old * (rel - 1)) & 15; eb = m_old;
          end
        end
        chk("cmd_ready", cmd_ready, !pending);
        chk("busy", busy, pending);
        chk("rsp_valid", rsp_valid, ev);
        chk("alu_func", alu_func, ef);
        chk("alu_a", alu_a, ea);
        chk("alu_b", alu_b, eb);
        if (ev) chk("rsp_data", rsp_data, m_acc);
        if (ev && rsp_ready) begin
          pending = 0;
        end else if (!pending && cmd_valid) begin
          pending = 1;
          acc_cyc = cyc;
          m_old = m_acc;
          m_op = cmd_op;
          m_data = cmd_data;
          m_acc = model_op(m_old, m_op, m_data);
          rsp_cyc = cyc + 2 + ((m_op == 5) ? m_data : 0);
        end
      end
    end
  end

  task automatic wait_accept(input string nm);
    int n = 0;
    while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!cmd_ready) chk({nm, "_accept_timeout"}, 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [3:0] d, input logic [3:0] lit,
                      input int eb, input int ea, input string nm);
    int n, nb, na;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_op = op; cmd_data = d; rsp_ready = 1;
    wait_accept(nm);
    cmd_valid = 0;
    nb = 0; na = 0; n = 0;
    while (!rsp_valid && n < 60) begin
      nb += int'(busy);
      na += int'(alu_func == 2'b11);
      @(posedge clk); #1;
      n++;
    end
    if (!rsp_valid) chk({nm, "_rsp_timeout"}, 0, 1);
    chk({nm, "_data"}, rsp_data, lit);
    chk({nm, "_busy_cycles"}, nb, eb);
    chk({nm, "_add_cycles"}, na, ea);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    send(3'b100, 4'h5, 4'h5, 1, 0, "load5");
    send(3'b011, 4'h3, 4'h8, 1, 1, "add3");
    send(3'b100, 4'hF, 4'hF, 1, 0, "loadF");
    send(3'b011, 4'h2, 4'h1, 1, 1, "add_wrap");
    send(3'b100, 4'h3, 4'h3, 1, 0, "load3");
    send(3'b010, 4'h5, 4'hE, 1, 0, "sub_wrap");
    send(3'b111, 4'h9, 4'h0, 1, 0, "clr");
    send(3'b110, 4'h7, 4'h0, 1, 0, "read");
    send(3'b100, 4'hC, 4'hC, 1, 0, "loadC");
    send(3'b000, 4'hA, 4'h8, 1, 0, "andA");
    send(3'b001, 4'h3, 4'hB, 1, 0, "or3");
    send(3'b100, 4'h3, 4'h3, 1, 0, "load3b");
    send(3'b101, 4'h5, 4'hF, 6, 5, "mul5");
    send(3'b100, 4'h6, 4'h6, 1, 0, "load6");
    send(3'b101, 4'h3, 4'h2, 4, 3, "mul3");
    send(3'b100, 4'h7, 4'h7, 1, 0, "load7");
    send(3'b101, 4'h0, 4'h0, 1, 0, "mul0");

    // Response back-pressure with a second command already waiting.
    send(3'b100, 4'h1, 4'h1, 1, 0, "load1");
    @(posedge clk); #1;
    cmd_valid = 1; cmd_op = 3'b011; cmd_data = 4'h2; rsp_ready = 0;
    wait_accept("hold");
    cmd_data = 4'h4;
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("hold_rsp_seen", rsp_valid, 1);
    chk("hold_data", rsp_data, 3);
    repeat (4) begin
      @(posedge clk); #1;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data_stable", rsp_data, 3);
      chk("hold_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    chk("post_hs_cmd_ready", cmd_ready, 1);
    chk("post_hs_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;
    cmd_valid = 0;
    chk("next_cmd_busy", busy, 1);
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("next_cmd_data", rsp_data, 7);
    @(posedge clk); #1;

    // Reset mid-multiply.
    send(3'b100, 4'h3, 4'h3, 1, 0, "load3c");
    @(posedge clk); #1;
    cmd_valid = 1; cmd_op = 3'b101; cmd_data = 4'hF;
    wait_accept("mulF");
    cmd_valid = 0;
    repeat (4) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_acc", rsp_data, 0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1;
    send(3'b110, 4'h0, 4'h0, 1, 0, "read_after_rst");

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
